// File: rtl/oreg_frame_pkg.sv
// Shared frame definitions for the oreg frame packer.
// Frame length includes a trailing XOR word when OREG_FRAME_CHECKSUM_EN is defined.
package oreg_frame_pkg;

  localparam logic [7:0] FRAME_MARKER     = 8'hA5;
  localparam int         DEFAULT_NUM_REGS = 8;

`ifdef OREG_FRAME_CHECKSUM_EN
  localparam int CSUM_WORDS = 1;
`else
  localparam int CSUM_WORDS = 0;
`endif

  // Header word + counter word + data registers (+ optional checksum).
  function automatic int frame_len(input int num_regs);
    return num_regs + 2 + CSUM_WORDS;
  endfunction

  localparam int FRAME_LEN = frame_len(DEFAULT_NUM_REGS);

  typedef logic [FRAME_LEN-1:0][31:0] frame_t;

  function automatic logic [31:0] header_word(input logic [7:0] seq, input int num_regs);
    return {FRAME_MARKER, seq, 16'(num_regs)};
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of whole frames; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Also exposes the entry behind the head for gapless reads.
module frame_fifo
  import oreg_frame_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = frame_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_wr_data,
  input  logic          i_pop,
  output T              o_head,
  output T              o_head_next,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_ptr_next;

  assign o_full        = (r_level == LW'(DEPTH));
  assign o_empty       = (r_level == '0);
  assign w_pop         = i_pop & ~o_empty;
  assign w_push        = i_push & (~o_full | w_pop);
  assign w_rd_ptr_next = r_rd_ptr + AW'(1);

  // NOTE: pointer/level state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_next;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity, and
  // resetting a wide array would turn RAM into a large flop bank.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_head_next = r_mem[w_rd_ptr_next];
  assign o_level     = r_level;

endmodule

// File: rtl/oreg_frame_packer.sv
// Snapshots oreg1..oregN on every sample-counter change and streams whole frames on AXI4-Stream.
// Define OREG_FRAME_CHECKSUM_EN to append an XOR checksum word to every frame.
module oreg_frame_packer
  import oreg_frame_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [31:0]                   count_i,
  input  logic [NUM_REGS*32-1:0]        regs_i,
  output logic [31:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [DROP_W-1:0]             drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int FLEN  = frame_len(NUM_REGS);
  localparam int IDX_W = $clog2(FLEN);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLEN - 1);

  typedef logic [FLEN-1:0][31:0] pframe_t;
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state;
  pframe_t           r_head;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [31:0]       r_count_q;
  logic              r_primed;
  logic [7:0]        r_seq;
  logic [DROP_W-1:0] r_drop;

  pframe_t           w_frame;
  pframe_t           w_head;
  pframe_t           w_head_next;
  pframe_t           w_next_frame;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_trig;
  logic              w_push_ok;
  logic              w_last_hs;
  logic              w_next_avail;
  logic [IDX_W-1:0]  w_idx_inc;

  assign w_trig    = r_primed & enable_i & (count_i != r_count_q);
  assign w_last_hs = (r_state == S_SEND) & m_tready & (r_idx == LAST_IDX);
  assign w_push_ok = w_trig & (~w_full | w_last_hs);
  assign w_idx_inc = r_idx + IDX_W'(1);

`ifdef OREG_FRAME_CHECKSUM_EN
  logic [31:0] w_csum;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_frame    = '0;
    w_frame[0] = header_word(r_seq, NUM_REGS);
    w_frame[1] = count_i;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_frame[i+2] = regs_i[i*32 +: 32];
    end
`ifdef OREG_FRAME_CHECKSUM_EN
    w_csum = '0;
    for (int i = 0; i < FLEN - 1; i++) begin
      w_csum = w_csum ^ w_frame[i];
    end
    w_frame[FLEN-1] = w_csum;
`endif
  end

  frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pframe_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_trig),
    .i_wr_data   (w_frame),
    .i_pop       (w_last_hs),
    .o_head      (w_head),
    .o_head_next (w_head_next),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // After the last-word pop the next frame is either already queued behind the
  // head, or is the one being pushed into a single-entry FIFO this very cycle.
  assign w_next_avail = (w_level > LW'(1)) | w_push_ok;
  assign w_next_frame = (w_level > LW'(1)) ? w_head_next : w_frame;

  always_ff @(posedge clk) begin
    r_count_q <= count_i;
    if (rst) begin
      r_primed <= 1'b0;
      r_seq    <= '0;
      r_drop   <= '0;
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (w_push_ok) begin
        r_seq <= r_seq + 8'd1;
      end else if (w_trig && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_head   <= w_head;
            r_idx    <= '0;
            r_tdata  <= w_head[0];
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (m_tready) begin
            if (r_idx == LAST_IDX) begin
              if (w_next_avail) begin
                r_head  <= w_next_frame;
                r_idx   <= '0;
                r_tdata <= w_next_frame[0];
                r_tlast <= 1'b0;
              end else begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_state  <= S_IDLE;
              end
            end else begin
              r_idx   <= w_idx_inc;
              r_tdata <= r_head[w_idx_inc];
              r_tlast <= (w_idx_inc == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_tdata      = r_tdata;
  assign m_tvalid     = r_tvalid;
  assign m_tlast      = r_tlast;
  assign drop_count_o = r_drop;
  assign fifo_level_o = w_level;

endmodule

// File: tb/tb_oreg_frame_packer.sv
// Scoreboard bench for oreg_frame_packer: a frame-level model queues expected beats,
// a monitor checks every handshake and AXI stall stability. Honours OREG_FRAME_CHECKSUM_EN.
module tb_oreg_frame_packer;

  localparam int NR    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
`ifdef OREG_FRAME_CHECKSUM_EN
  localparam int FL = NR + 3;
`else
  localparam int FL = NR + 2;
`endif

  logic              clk;
  logic              rst;
  logic              enable_i;
  logic [31:0]       count_i;
  logic [NR*32-1:0]  regs_i;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [DW-1:0]     drop_count_o;
  logic [$clog2(DEPTH):0] fifo_level_o;

  oreg_frame_packer #(.NUM_REGS(NR), .FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .count_i      (count_i),
    .regs_i       (regs_i),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .drop_count_o (drop_count_o),
    .fifo_level_o (fifo_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model state: frames held by the DUT, drops, sequence, trigger history.
  int          m_level;
  int          m_drops;
  logic [7:0]  m_seq;
  logic        m_primed;
  logic [31:0] m_count_q;
  int          n_trig;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return regs_i[i*32 +: 32];
  endfunction

  task automatic queue_frame();
    logic [31:0] w [FL];
    logic [31:0] x;
    w[0] = {8'hA5, m_seq, 16'(NR)};
    w[1] = count_i;
    for (int i = 0; i < NR; i++) w[i+2] = reg_word(i);
`ifdef OREG_FRAME_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < FL - 1; i++) x = x ^ w[i];
    w[FL-1] = x;
`else
    x = '0;
`endif
    for (int i = 0; i < FL; i++) exp_q.push_back('{data: w[i], last: (i == FL - 1)});
  endtask

  // One clock cycle with the inputs currently driven; the model decides push/drop.
  task automatic tick();
    logic trig;
    logic pop;
    trig = m_primed && enable_i && (count_i != m_count_q);
    pop  = m_tvalid && m_tready && m_tlast;
    if (trig) begin
      n_trig++;
      if (m_level < DEPTH || pop) begin
        queue_frame();
        m_seq = m_seq + 8'd1;
        m_level++;
      end else if (m_drops < (1 << DW) - 1) begin
        m_drops++;
      end
    end
    if (pop) m_level--;
    m_count_q = count_i;
    m_primed  = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    m_level   = 0;
    m_drops   = 0;
    m_seq     = 8'd0;
    m_primed  = 1'b0;
    m_count_q = count_i;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_drops", drop_count_o, 0);
  endtask

  task automatic drain(output int bubbles);
    int budget;
    bubbles  = 0;
    budget   = 0;
    m_tready = 1'b1;
    while (exp_q.size() > 0 && budget < 2000) begin
      if (!m_tvalid) bubbles++;
      tick();
      budget++;
    end
    check("drain_complete", exp_q.size(), 0);
    tick();
    check("drain_level", fifo_level_o, m_level);
  endtask

  // Monitor: checks each handshake against the scoreboard and stall stability.
  logic        p_rst = 1'b1;
  logic        p_valid;
  logic        p_ready;
  logic        p_last;
  logic [31:0] p_data;

  always @(negedge clk) begin
    beat_t b;
    #3;
    if (rst) begin
      p_rst = 1'b1;
    end else begin
      if (!p_rst && p_valid && !p_ready) begin
        check("stall_tvalid", m_tvalid, 1);
        check("stall_tdata", m_tdata, p_data);
        check("stall_tlast", m_tlast, p_last);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got %08h with nothing expected at %0t", m_tdata, $time);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", m_tdata, b.data);
          check("beat_last", m_tlast, b.last);
        end
      end
      p_rst = 1'b0;
    end
    p_valid = m_tvalid;
    p_ready = m_tready;
    p_last  = m_tlast;
    p_data  = m_tdata;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bub;
    n_trig   = 0;
    rst      = 1'b1;
    enable_i = 1'b1;
    count_i  = 32'd5;
    regs_i   = '0;
    m_tready = 1'b1;

    // Idle after reset with a static counter.
    do_reset();
    repeat (20) tick();
    check("idle_tvalid", m_tvalid, 0);
    check("idle_drops", drop_count_o, 0);

    // Single frame and its latency.
    for (int i = 0; i < NR; i++) regs_i[i*32 +: 32] = 32'h11 * (i + 1);
    count_i = 32'd6;
    tick();
    check("lat_not_yet", m_tvalid, 0);
    tick();
    check("lat_tvalid", m_tvalid, 1);
    check("lat_header", m_tdata, 32'hA500_0008);
    drain(bub);

    // Overflow under full backpressure, then gapless drain.
    do_reset();
    m_tready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      count_i = count_i + 32'd1;
      regs_i  = {NR{$urandom()}};
      tick();
    end
    check("ovf_level", fifo_level_o, 4);
    check("ovf_drops", drop_count_o, 2);
    check("ovf_head", m_tdata, 32'hA500_0008);
    drain(bub);
    check("ovf_no_bubbles", bub, 0);

    // Counter wrap is a change, then random backpressure.
    count_i = 32'hFFFF_FFFF;
    tick();
    count_i = 32'h0;
    tick();
    check("wrap_level", fifo_level_o, m_level);
    n_trig = 0;
    for (int cyc = 0; n_trig < 100 && cyc < 20000; cyc++) begin
      m_tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) begin
        count_i = ($urandom_range(0, 3) == 0) ? $urandom() : count_i + 32'd1;
        for (int i = 0; i < NR; i++) regs_i[i*32 +: 32] = $urandom();
      end
      tick();
      if (cyc % 8 == 0) begin
        check("rnd_level", fifo_level_o, m_level);
        check("rnd_drops", drop_count_o, m_drops);
      end
    end
    check("rnd_trig_count", n_trig, 100);
    drain(bub);
    check("rnd_final_drops", drop_count_o, m_drops);

    // Reset in the middle of a frame.
    m_tready = 1'b1;
    count_i  = count_i + 32'd1;
    tick();
    tick();
    repeat (4) tick();
    check("mid_word4", m_tdata, reg_word(2));
    do_reset();
    tick();
    count_i = count_i + 32'd1;
    tick();
    tick();
    check("post_rst_header", m_tdata, 32'hA500_0008);
    drain(bub);

    // Counter changes while disabled must not fire after re-enable.
    enable_i = 1'b0;
    repeat (3) begin
      count_i = count_i + 32'd3;
      tick();
    end
    enable_i = 1'b1;
    repeat (10) tick();
    check("dis_tvalid", m_tvalid, 0);
    check("dis_level", fifo_level_o, 0);
    check("dis_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
